// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, instruction field positions and fetch state encoding
package cpu_pkg;
   localparam int ADDR_W  = 10;
   localparam int INSTR_W = 16;
   localparam logic [2:0] OPC_ADD  = 3'b000;
   localparam logic [2:0] OPC_SUB  = 3'b001;
   localparam logic [2:0] OPC_ADDI = 3'b010;
   localparam logic [2:0] OPC_SUBI = 3'b011;
   localparam logic [2:0] OPC_BEQ  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS_MSB  = 9;
   localparam int RS_LSB  = 7;
   localparam int IMM_MSB = 6;
   localparam int IMM_LSB = 0;
   typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, otherwise contents hold
module if_id_reg #(
   parameter int ADDR_W  = 10,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic [INSTR_W-1:0] instr,
   input  logic [ADDR_W-1:0]  pc,
   input  logic [ADDR_W-1:0]  pc_next,
   output logic               valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_next
);
   always_ff @(posedge clk) begin
      if (rst) begin
         valid      <= 1'b0;
         id_instr   <= '0;
         id_pc      <= '0;
         id_pc_next <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid      <= 1'b1;
         id_instr   <= instr;
         id_pc      <= pc;
         id_pc_next <= pc_next;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory addressing, redirect/HALT control feeding the IF/ID register
module fetch_stage #(
   parameter int ADDR_W  = cpu_pkg::ADDR_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               id_ready,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_next,
   output logic               halted
);
   import cpu_pkg::*;
   fetch_state_e      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic              free;
   logic              is_halt;
   logic              load;
   logic              flush;
   assign pc_inc    = pc + ADDR_W'(1);
   assign free      = !id_valid || id_ready;
   assign is_halt   = imem_instr[OPC_MSB:OPC_LSB] == OPC_HALT;
   assign load      = !redirect_valid && state == FETCH && free;
   // In HALTED the consumed HALT word is retired by clearing valid
   assign flush     = redirect_valid || (state == HALTED && id_ready);
   assign imem_addr = pc;
   assign halted    = state == HALTED;
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= FETCH;
      end else begin
         pc    <= redirect_valid ? redirect_pc : load ? pc_inc : pc;
         state <= redirect_valid ? FETCH : (load && is_halt) ? HALTED : state;
      end
   end
   if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .flush      (flush),
      .instr      (imem_instr),
      .pc         (pc),
      .pc_next    (pc_inc),
      .valid      (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_pc_next (id_pc_next)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table for the directed scenarios, then a random run against a scoreboard
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  imem_addr;
   logic [15:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_pc = '0;
   logic        id_ready = 1'b1;
   logic        id_valid;
   logic [15:0] id_instr;
   logic [9:0]  id_pc;
   logic [9:0]  id_pc_next;
   logic        halted;
   logic [15:0] mem [1024];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr];
   fetch_stage dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_next(id_pc_next),
      .halted(halted)
   );
   typedef struct {
      logic        rst, rv;
      logic [9:0]  rpc;
      logic        rdy, e_valid;
      logic [9:0]  e_pc;
      logic [15:0] e_instr;
      logic [9:0]  e_addr;
      logic        e_halt;
   } vec_t;
   typedef struct {
      logic [9:0]  pc;
      logic [15:0] instr;
      logic [9:0]  nx;
   } sb_t;
   vec_t vt[31];
   sb_t  q[$];
   function automatic vec_t v(logic r, logic rv, logic [9:0] rpc, logic rdy, logic ev,
                              logic [9:0] ep, logic [15:0] ei, logic [9:0] ea, logic eh);
      vec_t t;
      t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.e_valid = ev;
      t.e_pc = ep; t.e_instr = ei; t.e_addr = ea; t.e_halt = eh;
      return t;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [9:0] exp_nx;
      logic       m_valid;
      logic [9:0] m_pc;
      sb_t        e;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 | 16'(i);
      mem[0] = 16'h4C06; mem[1] = 16'h4406; mem[2] = 16'h0083; mem[1023] = 16'h0000;
      //        rst rv rpc  rdy  val pc    instr     addr  halt
      vt[0]  = v(1, 0, 0,    1,   0, 0,    16'h0000, 0,    0);
      vt[1]  = v(0, 0, 0,    1,   1, 0,    16'h4C06, 1,    0);
      vt[2]  = v(0, 0, 0,    1,   1, 1,    16'h4406, 2,    0);
      vt[3]  = v(0, 0, 0,    1,   1, 2,    16'h0083, 3,    0);
      vt[4]  = v(0, 0, 0,    1,   1, 3,    16'h1003, 4,    0);
      vt[5]  = v(0, 0, 0,    1,   1, 4,    16'h1004, 5,    0);
      vt[6]  = v(0, 0, 0,    0,   1, 4,    16'h1004, 5,    0);
      vt[7]  = v(0, 0, 0,    0,   1, 4,    16'h1004, 5,    0);
      vt[8]  = v(0, 0, 0,    0,   1, 4,    16'h1004, 5,    0);
      vt[9]  = v(0, 0, 0,    1,   1, 5,    16'h1005, 6,    0);
      vt[10] = v(0, 0, 0,    1,   1, 6,    16'h1006, 7,    0);
      vt[11] = v(0, 1, 2,    0,   0, 0,    16'h0000, 2,    0);
      vt[12] = v(0, 0, 0,    1,   1, 2,    16'h0083, 3,    0);
      vt[13] = v(0, 1, 1023, 1,   0, 0,    16'h0000, 1023, 0);
      vt[14] = v(0, 0, 0,    1,   1, 1023, 16'h0000, 0,    0);
      vt[15] = v(0, 0, 0,    1,   1, 0,    16'h4C06, 1,    0);
      vt[16] = v(0, 1, 3,    1,   0, 0,    16'h0000, 3,    0);
      vt[17] = v(0, 0, 0,    0,   1, 3,    16'hE000, 4,    1);
      vt[18] = v(0, 0, 0,    0,   1, 3,    16'hE000, 4,    1);
      vt[19] = v(0, 0, 0,    1,   0, 0,    16'h0000, 4,    1);
      vt[20] = v(0, 0, 0,    1,   0, 0,    16'h0000, 4,    1);
      vt[21] = v(0, 1, 0,    1,   0, 0,    16'h0000, 0,    0);
      vt[22] = v(0, 0, 0,    1,   1, 0,    16'h4C06, 1,    0);
      vt[23] = v(0, 0, 0,    1,   1, 1,    16'h4406, 2,    0);
      vt[24] = v(0, 0, 0,    1,   1, 2,    16'h0083, 3,    0);
      vt[25] = v(0, 1, 5,    1,   0, 0,    16'h0000, 5,    0);
      vt[26] = v(0, 0, 0,    1,   1, 5,    16'h1005, 6,    0);
      vt[27] = v(0, 0, 0,    0,   1, 5,    16'h1005, 6,    0);
      vt[28] = v(1, 0, 0,    0,   0, 0,    16'h0000, 0,    0);
      vt[29] = v(0, 0, 0,    1,   1, 0,    16'h4C06, 1,    0);
      vt[30] = v(0, 0, 0,    1,   1, 1,    16'h4406, 2,    0);
      for (int i = 0; i < 31; i++) begin
         if (i == 16) mem[3] = 16'hE000;
         rst = vt[i].rst; redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc; id_ready = vt[i].rdy;
         step();
         chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
         chk($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vt[i].e_addr));
         chk($sformatf("v%0d halted", i), 32'(halted), 32'(vt[i].e_halt));
         if (vt[i].e_valid || vt[i].rst) begin
            exp_nx = vt[i].rst ? 10'd0 : vt[i].e_pc + 10'd1;
            chk($sformatf("v%0d id_pc", i), 32'(id_pc), 32'(vt[i].e_pc));
            chk($sformatf("v%0d id_instr", i), 32'(id_instr), 32'(vt[i].e_instr));
            chk($sformatf("v%0d id_pc_next", i), 32'(id_pc_next), 32'(exp_nx));
         end
      end
      // Random run: bit 13 cleared so no word decodes as HALT
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom) & 16'hDFFF;
      rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
      step();
      rst = 1'b0;
      m_valid = 1'b0; m_pc = 10'd0;
      q.delete();
      for (int c = 0; c < 400; c++) begin
         id_ready       = $urandom_range(0, 3) != 0;
         redirect_valid = $urandom_range(0, 11) == 0;
         redirect_pc    = 10'($urandom);
         #1;
         chk("sb imem_addr", 32'(imem_addr), 32'(m_pc));
         chk("sb id_valid", 32'(id_valid), 32'(m_valid));
         if (m_valid && id_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb underflow: got empty queue expected an entry");
            end else begin
               e = q.pop_front();
               chk("sb id_pc", 32'(id_pc), 32'(e.pc));
               chk("sb id_instr", 32'(id_instr), 32'(e.instr));
               chk("sb id_pc_next", 32'(id_pc_next), 32'(e.nx));
            end
         end else if (m_valid && redirect_valid && q.size() != 0) begin
            void'(q.pop_front());
         end
         if (redirect_valid) begin
            m_valid = 1'b0;
            m_pc    = redirect_pc;
         end else if (!m_valid || id_ready) begin
            q.push_back('{m_pc, mem[m_pc], m_pc + 10'd1});
            m_valid = 1'b1;
            m_pc    = m_pc + 10'd1;
         end
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
